// File: rtl/snn_frame_ctrl_if.sv
// Frame controller bus: UART byte strobe, input-RAM port, SNN core handshake and result.
// master = the frame controller, slave = its environment (UART, RAM, core).
interface snn_frame_ctrl_if #(
   parameter int ADDR_W = 10
);
   logic              rx_rdy;
   logic [7:0]        rx_data;
   logic              err_clr;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_data;
   logic              ram_we;
   logic [ADDR_W-1:0] core_addr;
   logic              core_start;
   logic              core_done;
   logic [3:0]        core_digit;
   logic [3:0]        digit;
   logic              digit_vld;
   logic              busy;
   logic              err;

   modport master (
      input  rx_rdy, rx_data, err_clr, core_addr, core_done, core_digit,
      output ram_addr, ram_data, ram_we, core_start, digit, digit_vld, busy, err
   );

   modport slave (
      output rx_rdy, rx_data, err_clr, core_addr, core_done, core_digit,
      input  ram_addr, ram_data, ram_we, core_start, digit, digit_vld, busy, err
   );
endinterface

// File: rtl/snn_frame_ctrl.sv
// snn_frame_ctrl: unpacks UART bytes LSB-first into 1-bit image RAM writes, starts the SNN core, latches its digit.
// Optional SNN_FRAME_RESYNC_EN: a partial frame is discarded (err set) after GAP_CYC idle cycles without a byte.
module snn_frame_ctrl #(
   parameter int NUM_BITS = 784,
   parameter int ADDR_W   = 10,
   parameter int GAP_CYC  = 50000
) (
   input  logic             clk,
   input  logic             rst_n,
   snn_frame_ctrl_if.master bus
);
   localparam int NUM_BYTES = NUM_BITS / 8;
   localparam int BC_W      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

   typedef enum logic [1:0] {IDLE, UNPACK, START, RUN} state_e;

   state_e            state_q, state_d;
   logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        byte_q, byte_d;
   logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
   logic              ram_we_q, ram_we_d;
   logic              ram_data_q, ram_data_d;
   logic              start_q, start_d;
   logic [3:0]        digit_q, digit_d;
   logic              vld_q, vld_d;
   logic              err_q, err_d;
   logic              overrun, last_bit, last_byte, gap_hit;

   assign overrun   = (state_q != IDLE) && bus.rx_rdy;
   assign last_bit  = (bit_cnt_q == 3'd7);
   assign last_byte = (byte_cnt_q == BC_W'(NUM_BYTES - 1));

`ifdef SNN_FRAME_RESYNC_EN
   localparam int GAP_W = $clog2(GAP_CYC + 1);
   logic [GAP_W-1:0] gap_q;

   // Counts idle cycles inside a partially received frame; held while unpacking.
   assign gap_hit = (state_q == IDLE) && !bus.rx_rdy && (byte_cnt_q != '0)
                    && (gap_q == GAP_W'(GAP_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_q <= '0;
      end else if ((state_q == IDLE) && bus.rx_rdy) begin
         gap_q <= '0;
      end else if (gap_hit) begin
         gap_q <= '0;
      end else if ((state_q == IDLE) && (byte_cnt_q != '0)) begin
         gap_q <= gap_q + 1'b1;
      end
   end
`else
   localparam int unused_gap_cyc = GAP_CYC;
   assign gap_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.rx_rdy) state_d = UNPACK;
         UNPACK:  if (last_bit) state_d = last_byte ? START : IDLE;
         START:   state_d = RUN;
         RUN:     if (bus.core_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      byte_cnt_d = byte_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      byte_d     = byte_q;
      ld_addr_d  = ld_addr_q;
      ram_we_d   = 1'b0;
      ram_data_d = 1'b0;
      start_d    = 1'b0;
      digit_d    = digit_q;
      vld_d      = vld_q;
      err_d      = err_q;
      // A fresh overrun wins over a same-cycle clear.
      if (bus.err_clr) err_d = 1'b0;
      if (overrun || gap_hit) err_d = 1'b1;
      if (gap_hit) byte_cnt_d = '0;
      unique case (state_q)
         IDLE: begin
            if (bus.rx_rdy) begin
               byte_d     = bus.rx_data;
               bit_cnt_d  = 3'd0;
               ld_addr_d  = ADDR_W'({byte_cnt_q, 3'b000});
               ram_we_d   = 1'b1;
               ram_data_d = bus.rx_data[0];
               vld_d      = 1'b0;
            end
         end
         UNPACK: begin
            if (last_bit) begin
               bit_cnt_d  = 3'd0;
               ld_addr_d  = '0;
               byte_cnt_d = last_byte ? '0 : byte_cnt_q + 1'b1;
               start_d    = last_byte;
            end else begin
               bit_cnt_d  = bit_cnt_q + 3'd1;
               ld_addr_d  = ld_addr_q + 1'b1;
               ram_we_d   = 1'b1;
               ram_data_d = byte_q[bit_cnt_q + 3'd1];
            end
         end
         RUN: begin
            if (bus.core_done) begin
               digit_d = bus.core_digit;
               vld_d   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt_q <= '0;
         bit_cnt_q  <= '0;
         byte_q     <= '0;
         ld_addr_q  <= '0;
         ram_we_q   <= 1'b0;
         ram_data_q <= 1'b0;
         start_q    <= 1'b0;
         digit_q    <= '0;
         vld_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_q     <= byte_d;
         ld_addr_q  <= ld_addr_d;
         ram_we_q   <= ram_we_d;
         ram_data_q <= ram_data_d;
         start_q    <= start_d;
         digit_q    <= digit_d;
         vld_q      <= vld_d;
         err_q      <= err_d;
      end
   end

   // The core owns the RAM address from START until its done is seen.
   assign bus.ram_addr   = ((state_q == START) || (state_q == RUN)) ? bus.core_addr : ld_addr_q;
   assign bus.ram_we     = ram_we_q;
   assign bus.ram_data   = ram_data_q;
   assign bus.core_start = start_q;
   assign bus.digit      = digit_q;
   assign bus.digit_vld  = vld_q;
   assign bus.err        = err_q;
   assign bus.busy       = (state_q != IDLE);
endmodule

// File: doc/snn_frame_ctrl.md
Name: snn_frame_ctrl

Overview:
Frame sequencer between the UART receiver, the 784-bit input-image RAM and the SNN core. It unpacks 98 received bytes into 784 single-bit RAM writes, pulses the core's start, then arbitrates the RAM address port to the core. It also captures the classified digit on done. One frame per classification; bytes arriving while the block is busy are dropped and flagged.

Parameters:
NUM_BITS, 784, image bits per frame (must be a multiple of 8)
ADDR_W, 10, input RAM address width
GAP_CYC, 50000, inter-byte gap limit in clk cycles (used only with SNN_FRAME_RESYNC_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx_rdy  input  1  one-cycle strobe, rx_data valid
rx_data  input  8  received byte
err_clr  input  1  clears sticky err
ram_addr  output  ADDR_W  input RAM address (muxed)
ram_data  output  1  input RAM write data
ram_we  output  1  input RAM write enable
core_addr  input  ADDR_W  SNN core's input RAM address request
core_start  output  1  one-cycle start pulse to the SNN core
core_done  input  1  SNN core done
core_digit  input  4  SNN core result
digit  output  4  latched result
digit_vld  output  1  result valid
busy  output  1  high in any state other than IDLE
err  output  1  sticky overrun flag

Behaviour:
- Reset (async, rst_n=0): state IDLE; byte counter 0; bit counter 0; all outputs 0. RAM contents are untouched.
- Registered outputs: ram_we, ram_data, core_start, digit, digit_vld, err. ram_addr is the mux described below.
- States:
  - IDLE: waits for rx_rdy.
  - UNPACK: exactly 8 cycles.
  - START: 1 cycle.
  - RUN: waits for core_done.
- IDLE, rx_rdy=1 at cycle T: latch the byte, go to UNPACK, clear digit_vld.
- UNPACK write timing: cycles T+1..T+8 have ram_we=1 and ram_addr = 8*byte_cnt + i, where i = 0..7.
- UNPACK bit order: ram_data = rx_data[i], LSB first.
- After the 8th write: byte_cnt increments.
  - If byte_cnt was NUM_BITS/8-1, go to START and reset byte_cnt to 0.
  - Otherwise return to IDLE.
- START: core_start=1 for exactly one cycle (the cycle after the write to address NUM_BITS-1). Next state is RUN.
- RUN: ram_we=0. On the first cycle with core_done=1: digit <= core_digit, digit_vld <= 1, state becomes IDLE.
- Address mux: ram_addr = core_addr in START and RUN; otherwise the loader address (0 in IDLE).
- core_done is ignored outside RUN.
- Overrun: rx_rdy in UNPACK, START or RUN drops the byte and sets err=1. Counters are unaffected.
- err clears only on err_clr=1 or reset. If err_clr and a new overrun occur in the same cycle, err=1.
- Simultaneous rx_rdy and core_done in RUN: the byte is dropped (err=1) and the result is latched.
- digit_vld holds high from core_done until the first byte of the next frame is accepted.
- Reset mid-frame aborts the frame; the next accepted byte writes addresses 0..7.

Optional Feature:
SNN_FRAME_RESYNC_EN
- Defined: a gap counter runs in IDLE while byte_cnt != 0.
  - If the gap reaches GAP_CYC cycles without rx_rdy, byte_cnt resets to 0 (partial frame discarded) and err is set.
  - The counter clears on each accepted byte.
- Undefined: no gap counter; a partial frame waits indefinitely; GAP_CYC is unused.

Test Plan:
1. Hold rst_n=0, then release -> all outputs 0, busy=0, ram_addr=0, state IDLE.
2. First byte 0xA5 -> writes at addr 0..7 with data 1,0,1,0,0,1,0,1; ram_we high exactly 8 cycles; busy=1 during the writes, then 0.
3. 98 bytes of 0xFF with 20-cycle gaps -> 784 writes of 1 to addr 0..783. core_start pulses once, in the cycle after the addr-783 write. err=0.
4. Core model drives core_addr=0..783 and asserts core_done after 100 cycles with core_digit=7 -> ram_addr tracks core_addr during RUN; digit=7 and digit_vld=1 the next cycle; state IDLE. Next accepted byte clears digit_vld.
5. rx_rdy 2 cycles after an accepted byte -> byte dropped, err=1, next write sequence uses the correct next addresses. err_clr pulse -> err=0.
6. Async rst_n low during UNPACK of byte 50 -> outputs 0 immediately. The next frame starts at addr 0. With SNN_FRAME_RESYNC_EN, GAP_CYC=100 and a 150-cycle gap after byte 10 -> err=1 and the next byte writes addr 0..7.
